can_frame_seq: RTL and testbench
================================

# can_frame_seq

Receive-side CAN 2.0 frame sequencer. It runs on the bit clock beside the bit unstuffer and tracks frame fields from SOF to IFS. It controls the unstuffer's enable: unstuffing is on only from the ID through the CRC, and off for the delimiters, ACK and EOF. It captures ID, DLC and data bytes, and checks CRC-15. It flags form, stuff and CRC errors to the downstream frame buffer.

## Interface
- `BUSINT_BITS`, default 11: number of consecutive recessive bits needed to leave WAIT (bus integration and error recovery).
- `clkin`  in  1: bit clock. All logic updates on posedge.
- `rstn`  in  1: asynchronous, active-low reset.
- `bitin`  in  1: unstuffed bit (unstuffer `rxout`). 1 = recessive.
- `bitvld`  in  1: `bitin` is a data bit this cycle. Low during stuff-bit cycles.
- `stuff_err`  in  1: unstuffer error flag.
- `unstuff_en`  out  1: unstuffer enable.
- `state`  out  4: current FSM state, for debug.
- `id`  out  29: received identifier, right-aligned. Standard frames use `id[10:0]`.
- `ide`, `rtr`  out  1 each: frame-type flags.
- `dlc`  out  4: raw DLC.
- `data_byte`  out  8; `byte_vld`  out  1: byte strobe.
- `ack_drv`  out  1: drive dominant in the ACK slot.
- `frame_ok`, `form_err`, `crc_err`, `stf_err`  out  1 each: one-cycle pulses.

## Operation
- The FSM advances only on cycles with `bitvld`=1. All other cycles hold state, except for the `stuff_err` abort.
- States:
  - WAIT: count consecutive `bitin`=1. Any 0 clears the count. At `BUSINT_BITS` go to IDLE.
  - IDLE: `bitin`=0 is SOF; clear the CRC, clear all counters, go to ID.
  - ID: 11 bits, MSB first.
  - RTR (or SRR for extended).
  - IDE.
  - R0.
  - DLC: 4 bits.
  - DATA.
  - CRC: 15 bits.
  - CRCDEL.
  - ACK.
  - ACKDEL.
  - EOF: 7 bits.
  - IFS: 3 bits, then IDLE.
- DATA holds `8*min(dlc,8)` bits. When `rtr`=1 or DLC=0, DATA is skipped (DLC goes straight to CRC).
- `unstuff_en`=1 only in states ID..CRC, inclusive (Moore, decoded from the state register).
- A 6-bit field counter resets on every state entry and wraps to 0 at the field length.
- CRC-15, polynomial 0x4599, covers SOF through the last DATA bit. The received CRC bits shift into a separate register.
- The CRC compare is registered on entry to CRCDEL. On mismatch, `crc_err` pulses and `ack_drv` stays low.
- `ack_drv`=1 for the whole ACK state when the CRC matched.
- Form checks:
  - CRCDEL, ACKDEL and EOF bits must be 1. Otherwise pulse `form_err` and go to WAIT.
  - In IFS, a 0 bit is treated as overload: go to WAIT, with no error pulse.
  - R0 value is ignored.
- `stuff_err`=1 while `unstuff_en`=1: pulse `stf_err` and go to WAIT that cycle, regardless of `bitvld`.
- `frame_ok` pulses on the last EOF bit if no error occurred in the frame.
- Outputs `id`, `ide`, `rtr` and `dlc` are valid from the cycle after their field completes. They hold until the next SOF.

## Timing
- Reset values:
  - state = WAIT.
  - All outputs 0, including the counters, `id`, `dlc` and `data_byte`.
- Reset may assert mid-frame; the FSM returns to WAIT and bus integration restarts.
- `byte_vld` pulses one cycle after the 8th bit of each byte is sampled, with `data_byte` valid in the same cycle.
- Error pulses are registered: one cycle after the offending bit.
- Simultaneous `stuff_err` and the last CRC bit: the error wins and no CRC compare occurs.
- DLC values 9..15: `dlc` reports the raw value, but the frame carries 8 data bytes.

## Configuration
- `CAN_EXT_ID_EN` defined:
  - IDE=1 selects the extended path: ID-B (18 bits, appended to `id`), RTR, R1, R0, DLC.
  - `unstuff_en` stays high through the extended fields.
- `CAN_EXT_ID_EN` undefined:
  - IDE=1 pulses `form_err` and goes to WAIT.
  - `id[28:11]` are tied to 0.

## Test plan
- After reset, 11 ones → IDLE. Then a standard frame (ID=0x123, DLC=2, data 0xA5 0x5A, correct CRC) → `byte_vld` twice with those values, `ack_drv` high in the ACK slot, `frame_ok` on EOF bit 7.
- Same frame with one CRC bit flipped → `crc_err` on CRCDEL entry, `ack_drv` stays 0, no `frame_ok`.
- `stuff_err` raised in the 4th ID bit → `stf_err` next cycle, state = WAIT, `unstuff_en`=0. A new frame is accepted only after 11 ones.
- ACKDEL driven 0 → `form_err`, then WAIT.
- RTR=1 with DLC=8 → no `byte_vld`, CRC directly after DLC, `frame_ok`.
- With `CAN_EXT_ID_EN`: extended ID 0x1ABCDEF0, DLC=0 → `id`=0x1ABCDEF0, `ide`=1, `frame_ok`. Without the macro, the same frame → `form_err` at IDE.

Source files
------------

// File: rtl/can_frame_seq.sv
// Receive-side CAN 2.0 frame sequencer: tracks SOF..IFS, gates the unstuffer, captures fields, checks CRC-15.
// Define CAN_EXT_ID_EN to accept 29-bit extended frames; otherwise IDE=1 is a form error.
module can_frame_seq #(
    parameter int BUSINT_BITS = 11
) (
    input  logic        clkin,
    input  logic        rstn,
    input  logic        bitin,
    input  logic        bitvld,
    input  logic        stuff_err,
    output logic        unstuff_en,
    output logic [3:0]  state,
    output logic [28:0] id,
    output logic        ide,
    output logic        rtr,
    output logic [3:0]  dlc,
    output logic [7:0]  data_byte,
    output logic        byte_vld,
    output logic        ack_drv,
    output logic        frame_ok,
    output logic        form_err,
    output logic        crc_err,
    output logic        stf_err
);

    typedef enum logic [3:0] {
        S_WAIT, S_IDLE, S_ID, S_RTR, S_IDE, S_IDB, S_R0, S_DLC,
        S_DATA, S_CRC, S_CRCDEL, S_ACK, S_ACKDEL, S_EOF, S_IFS
    } state_t;

    localparam logic [5:0] BUSINT_LAST = 6'(BUSINT_BITS - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [14:0] crc_q, crc_d;
    logic [14:0] crc_rx_q, crc_rx_d;
    logic [28:0] id_q, id_d;
    logic        ide_q, ide_d;
    logic        rtr_q, rtr_d;
    logic [3:0]  dlc_q, dlc_d;
    logic [6:0]  data_sr_q, data_sr_d;
    logic [7:0]  data_byte_q, data_byte_d;
    logic        byte_vld_q, byte_vld_d;
    logic        crc_ok_q, crc_ok_d;
    logic        frame_ok_q, frame_ok_d;
    logic        form_err_q, form_err_d;
    logic        crc_err_q, crc_err_d;
    logic        stf_err_q, stf_err_d;

    logic        crc_nxt;
    logic [14:0] crc_upd;
    logic [14:0] crc_rx_nxt;
    logic [3:0]  dlc_nxt;
    logic [2:0]  last_byte;
    logic [28:0] id_shift;

    assign crc_nxt    = bitin ^ crc_q[14];
    assign crc_upd    = {crc_q[13:0], 1'b0} ^ (crc_nxt ? 15'h4599 : 15'h0000);
    assign crc_rx_nxt = {crc_rx_q[13:0], bitin};
    assign dlc_nxt    = {dlc_q[2:0], bitin};
    // DLC 9..15 still carries 8 bytes
    assign last_byte  = dlc_q[3] ? 3'd7 : (dlc_q[2:0] - 3'd1);
`ifdef CAN_EXT_ID_EN
    assign id_shift   = {id_q[27:0], bitin};
`else
    assign id_shift   = {18'd0, id_q[9:0], bitin};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        crc_rx_d    = crc_rx_q;
        id_d        = id_q;
        ide_d       = ide_q;
        rtr_d       = rtr_q;
        dlc_d       = dlc_q;
        data_sr_d   = data_sr_q;
        data_byte_d = data_byte_q;
        crc_ok_d    = crc_ok_q;
        byte_vld_d  = 1'b0;
        frame_ok_d  = 1'b0;
        form_err_d  = 1'b0;
        crc_err_d   = 1'b0;
        stf_err_d   = 1'b0;

        if (stuff_err && unstuff_en) begin
            state_d   = S_WAIT;
            stf_err_d = 1'b1;
        end else if (bitvld) begin
            cnt_d = cnt_q + 6'd1;
            if (state_q >= S_ID && state_q <= S_DATA) begin
                crc_d = crc_upd;
            end
            case (state_q)
                S_WAIT: begin
                    if (!bitin)                    cnt_d   = '0;
                    else if (cnt_q == BUSINT_LAST) state_d = S_IDLE;
                end
                S_IDLE: begin
                    cnt_d = '0;
                    if (!bitin) begin
                        state_d  = S_ID;
                        crc_d    = '0;
                        crc_rx_d = '0;
                        id_d     = '0;
                        ide_d    = 1'b0;
                        rtr_d    = 1'b0;
                        dlc_d    = '0;
                        crc_ok_d = 1'b0;
                    end
                end
                S_ID: begin
                    id_d = id_shift;
                    if (cnt_q == 6'd10) state_d = S_RTR;
                end
                S_RTR: begin
                    // first pass is RTR (standard) or SRR; second pass, after ID-B, is the real RTR
                    rtr_d   = bitin;
                    state_d = ide_q ? S_R0 : S_IDE;
                end
                S_IDE: begin
                    if (bitin) begin
`ifdef CAN_EXT_ID_EN
                        ide_d   = 1'b1;
                        state_d = S_IDB;
`else
                        form_err_d = 1'b1;
                        state_d    = S_WAIT;
`endif
                    end else begin
                        state_d = S_R0;
                    end
                end
                S_IDB: begin
                    id_d = id_shift;
                    if (cnt_q == 6'd17) state_d = S_RTR;
                end
                S_R0: begin
                    if (!ide_q || cnt_q == 6'd1) state_d = S_DLC;
                end
                S_DLC: begin
                    dlc_d = dlc_nxt;
                    if (cnt_q == 6'd3) state_d = (rtr_q || dlc_nxt == 4'd0) ? S_CRC : S_DATA;
                end
                S_DATA: begin
                    data_sr_d = {data_sr_q[5:0], bitin};
                    if (cnt_q[2:0] == 3'd7) begin
                        data_byte_d = {data_sr_q, bitin};
                        byte_vld_d  = 1'b1;
                    end
                    if (cnt_q == {last_byte, 3'b111}) state_d = S_CRC;
                end
                S_CRC: begin
                    crc_rx_d = crc_rx_nxt;
                    if (cnt_q == 6'd14) begin
                        crc_ok_d  = (crc_rx_nxt == crc_q);
                        crc_err_d = (crc_rx_nxt != crc_q);
                        state_d   = S_CRCDEL;
                    end
                end
                S_CRCDEL, S_ACKDEL: begin
                    if (!bitin) begin
                        form_err_d = 1'b1;
                        state_d    = S_WAIT;
                    end else begin
                        state_d = (state_q == S_CRCDEL) ? S_ACK : S_EOF;
                    end
                end
                S_ACK: state_d = S_ACKDEL;
                S_EOF: begin
                    if (!bitin) begin
                        form_err_d = 1'b1;
                        state_d    = S_WAIT;
                    end else if (cnt_q == 6'd6) begin
                        frame_ok_d = crc_ok_q;
                        state_d    = S_IFS;
                    end
                end
                S_IFS: begin
                    if (!bitin)              state_d = S_WAIT;
                    else if (cnt_q == 6'd2)  state_d = S_IDLE;
                end
                default: state_d = S_WAIT;
            endcase
        end

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_WAIT;
            cnt_q       <= '0;
            crc_q       <= '0;
            crc_rx_q    <= '0;
            id_q        <= '0;
            ide_q       <= 1'b0;
            rtr_q       <= 1'b0;
            dlc_q       <= '0;
            data_sr_q   <= '0;
            data_byte_q <= '0;
            byte_vld_q  <= 1'b0;
            crc_ok_q    <= 1'b0;
            frame_ok_q  <= 1'b0;
            form_err_q  <= 1'b0;
            crc_err_q   <= 1'b0;
            stf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            crc_rx_q    <= crc_rx_d;
            id_q        <= id_d;
            ide_q       <= ide_d;
            rtr_q       <= rtr_d;
            dlc_q       <= dlc_d;
            data_sr_q   <= data_sr_d;
            data_byte_q <= data_byte_d;
            byte_vld_q  <= byte_vld_d;
            crc_ok_q    <= crc_ok_d;
            frame_ok_q  <= frame_ok_d;
            form_err_q  <= form_err_d;
            crc_err_q   <= crc_err_d;
            stf_err_q   <= stf_err_d;
        end
    end

    assign unstuff_en = (state_q >= S_ID) && (state_q <= S_CRC);
    assign ack_drv    = (state_q == S_ACK) && crc_ok_q;
    assign state      = state_q;
    assign id         = id_q;
    assign ide        = ide_q;
    assign rtr        = rtr_q;
    assign dlc        = dlc_q;
    assign data_byte  = data_byte_q;
    assign byte_vld   = byte_vld_q;
    assign frame_ok   = frame_ok_q;
    assign form_err   = form_err_q;
    assign crc_err    = crc_err_q;
    assign stf_err    = stf_err_q;

endmodule

// File: tb/tb_can_frame_seq.sv
// Directed bench for can_frame_seq: integration, good/bad-CRC frames, stuff/form errors, RTR, DLC>8, extended ID.
// Build with +define+CAN_EXT_ID_EN to exercise the extended-frame path.
module tb_can_frame_seq;

    localparam logic [3:0] ST_WAIT = 4'd0;
    localparam logic [3:0] ST_IDLE = 4'd1;
    localparam logic [3:0] ST_DATA = 4'd8;
    localparam logic [3:0] ST_CRC  = 4'd9;

    logic        clkin = 1'b0;
    logic        rstn = 1'b0;
    logic        bitin = 1'b1;
    logic        bitvld = 1'b0;
    logic        stuff_err = 1'b0;
    logic        unstuff_en;
    logic [3:0]  state;
    logic [28:0] id;
    logic        ide, rtr;
    logic [3:0]  dlc;
    logic [7:0]  data_byte;
    logic        byte_vld, ack_drv, frame_ok, form_err, crc_err, stf_err;

    int checks = 0;
    int failures = 0;
    logic [7:0] rxBytes[$];
    int okPulses = 0;
    int crcErrPulses = 0;
    int formErrPulses = 0;

    can_frame_seq #(.BUSINT_BITS(11)) dut (
        .clkin(clkin), .rstn(rstn), .bitin(bitin), .bitvld(bitvld), .stuff_err(stuff_err),
        .unstuff_en(unstuff_en), .state(state), .id(id), .ide(ide), .rtr(rtr), .dlc(dlc),
        .data_byte(data_byte), .byte_vld(byte_vld), .ack_drv(ack_drv), .frame_ok(frame_ok),
        .form_err(form_err), .crc_err(crc_err), .stf_err(stf_err)
    );

    always #5 clkin = ~clkin;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bus bit, optionally preceded by a bitvld-low stall cycle; samples outputs after the edge
    task automatic applyStimulus(input logic b, input logic se, input logic stall);
        if (stall) begin
            @(negedge clkin);
            bitin = ~b; bitvld = 1'b0; stuff_err = 1'b0;
        end
        @(negedge clkin);
        bitin = b; bitvld = 1'b1; stuff_err = se;
        @(posedge clkin);
        #1;
        bitvld = 1'b0; stuff_err = 1'b0;
        if (byte_vld) rxBytes.push_back(data_byte);
        okPulses      += int'(frame_ok);
        crcErrPulses  += int'(crc_err);
        formErrPulses += int'(form_err);
    endtask

    task automatic idleBus(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic runFrame(input string nm, input logic [28:0] fid, input logic ext, input logic rtrBit,
                            input logic [3:0] dlcVal, input int nBytes, input logic [63:0] payload,
                            input logic flipCrc, input logic ackDelBit);
        logic frm[$];
        logic [14:0] crc;
        logic nxt;
        logic aborted;
        logic [7:0] expByte;
        int dlcLast, crcLast, crcDel, ackDel, eofLast;
        frm.push_back(1'b0);
        if (ext) begin
            for (int i = 28; i >= 18; i--) frm.push_back(fid[i]);
            frm.push_back(1'b1);
            frm.push_back(1'b1);
            for (int i = 17; i >= 0; i--) frm.push_back(fid[i]);
            frm.push_back(rtrBit);
            frm.push_back(1'b0);
            frm.push_back(1'b0);
        end else begin
            for (int i = 10; i >= 0; i--) frm.push_back(fid[i]);
            frm.push_back(rtrBit);
            frm.push_back(1'b0);
            frm.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) frm.push_back(dlcVal[i]);
        dlcLast = frm.size() - 1;
        for (int i = 0; i < nBytes * 8; i++) frm.push_back(payload[63 - i]);
        crc = 15'd0;
        foreach (frm[k]) begin
            nxt = frm[k] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (nxt) crc = crc ^ 15'h4599;
        end
        if (flipCrc) crc[0] = ~crc[0];
        for (int i = 14; i >= 0; i--) frm.push_back(crc[i]);
        crcLast = frm.size() - 1;
        frm.push_back(1'b1);
        crcDel = frm.size() - 1;
        frm.push_back(1'b0);
        frm.push_back(ackDelBit);
        ackDel = frm.size() - 1;
        for (int i = 0; i < 7; i++) frm.push_back(1'b1);
        eofLast = frm.size() - 1;
        for (int i = 0; i < 3; i++) frm.push_back(1'b1);

        rxBytes.delete();
        okPulses = 0; crcErrPulses = 0; formErrPulses = 0;
        aborted = 1'b0;
        for (int i = 0; i < frm.size(); i++) begin
            applyStimulus(frm[i], 1'b0, (i % 7) == 3);
            if (i == dlcLast) begin
                checkOutput({nm, " id"}, 32'(id), 32'(fid));
                checkOutput({nm, " ide"}, 32'(ide), 32'(ext));
                checkOutput({nm, " rtr"}, 32'(rtr), 32'(rtrBit));
                checkOutput({nm, " dlc"}, 32'(dlc), 32'(dlcVal));
                checkOutput({nm, " state after dlc"}, 32'(state),
                            32'((rtrBit || dlcVal == 4'd0) ? ST_CRC : ST_DATA));
            end
            if (i == crcLast) begin
                checkOutput({nm, " crc_err"}, 32'(crc_err), 32'(flipCrc));
                checkOutput({nm, " unstuff_en at crcdel"}, 32'(unstuff_en), 32'd0);
            end
            if (i == crcDel) checkOutput({nm, " ack_drv"}, 32'(ack_drv), 32'(!flipCrc));
            if (i == ackDel && !ackDelBit) begin
                checkOutput({nm, " form_err"}, 32'(form_err), 32'd1);
                checkOutput({nm, " state after form_err"}, 32'(state), 32'(ST_WAIT));
                aborted = 1'b1;
                break;
            end
            if (i == eofLast) checkOutput({nm, " frame_ok"}, 32'(frame_ok), 32'(!flipCrc));
        end
        if (aborted) begin
            checkOutput({nm, " frame_ok count"}, 32'(okPulses), 32'd0);
        end else begin
            checkOutput({nm, " byte count"}, 32'(rxBytes.size()), 32'(nBytes));
            for (int k = 0; k < nBytes; k++) begin
                expByte = payload[63 - 8 * k -: 8];
                checkOutput($sformatf("%s byte%0d", nm, k),
                            (k < rxBytes.size()) ? 32'(rxBytes[k]) : 32'hFFFF_FFFF, 32'(expByte));
            end
            checkOutput({nm, " frame_ok count"}, 32'(okPulses), 32'(!flipCrc));
            checkOutput({nm, " crc_err count"}, 32'(crcErrPulses), 32'(flipCrc));
            checkOutput({nm, " form_err count"}, 32'(formErrPulses), 32'd0);
            checkOutput({nm, " state after ifs"}, 32'(state), 32'(ST_IDLE));
        end
    endtask

`ifndef CAN_EXT_ID_EN
    task automatic extReject();
        logic [28:0] f;
        f = 29'h1ABCDEF0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 28; i >= 18; i--) applyStimulus(f[i], 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ext form_err", 32'(form_err), 32'd1);
        checkOutput("ext state", 32'(state), 32'(ST_WAIT));
        checkOutput("ext id upper", 32'(id[28:11]), 32'd0);
    endtask
`endif

    initial begin
        repeat (2) @(posedge clkin);
        #1;
        checkOutput("reset state", 32'(state), 32'(ST_WAIT));
        checkOutput("reset id", 32'(id), 32'd0);
        checkOutput("reset dlc", 32'(dlc), 32'd0);
        checkOutput("reset data_byte", 32'(data_byte), 32'd0);
        checkOutput("reset flags", {23'd0, unstuff_en, ack_drv, byte_vld, frame_ok, form_err,
                                    crc_err, stf_err, ide, rtr}, 32'd0);
        @(negedge clkin);
        rstn = 1'b1;

        idleBus(11);
        checkOutput("integrate idle", 32'(state), 32'(ST_IDLE));

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("in id unstuff_en", 32'(unstuff_en), 32'd1);
        @(negedge clkin);
        rstn = 1'b0;
        #1;
        checkOutput("async reset state", 32'(state), 32'(ST_WAIT));
        checkOutput("async reset id", 32'(id), 32'd0);
        checkOutput("async reset unstuff_en", 32'(unstuff_en), 32'd0);
        @(negedge clkin);
        rstn = 1'b1;

        idleBus(5);
        applyStimulus(1'b0, 1'b0, 1'b0);
        idleBus(10);
        checkOutput("zero restarts count", 32'(state), 32'(ST_WAIT));
        idleBus(1);
        checkOutput("integrate after zero", 32'(state), 32'(ST_IDLE));

        runFrame("stdA", 29'h123, 1'b0, 1'b0, 4'd2, 2, 64'hA55A_0000_0000_0000, 1'b0, 1'b1);
        runFrame("badcrc", 29'h123, 1'b0, 1'b0, 4'd2, 2, 64'hA55A_0000_0000_0000, 1'b1, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("stuff stf_err", 32'(stf_err), 32'd1);
        checkOutput("stuff state", 32'(state), 32'(ST_WAIT));
        checkOutput("stuff unstuff_en", 32'(unstuff_en), 32'd0);
        idleBus(10);
        checkOutput("stuff still waiting", 32'(state), 32'(ST_WAIT));
        idleBus(1);
        checkOutput("stuff reintegrated", 32'(state), 32'(ST_IDLE));

        runFrame("ackdel", 29'h2AA, 1'b0, 1'b0, 4'd1, 1, 64'h3C00_0000_0000_0000, 1'b0, 1'b0);
        idleBus(11);
        checkOutput("ackdel reintegrated", 32'(state), 32'(ST_IDLE));

        runFrame("rtr", 29'h456, 1'b0, 1'b1, 4'd8, 0, 64'd0, 1'b0, 1'b1);
        runFrame("dlc9", 29'h7F0, 1'b0, 1'b0, 4'd9, 8, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);

`ifdef CAN_EXT_ID_EN
        runFrame("ext", 29'h1ABCDEF0, 1'b1, 1'b0, 4'd0, 0, 64'd0, 1'b0, 1'b1);
`else
        extReject();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
